bus_switch_seq: RTL and testbench

Parametrised, registered successor to the combinational data-bus switch control: NUM_SW bidirectional switches, each joining a lower and an upper data-bus segment.
Each switch runs a direction FSM that enforces a dead-time turnaround before reversing, so the two segments are never driven against each other.
Each switch also masks bits on its downstream path and flags up/down request conflicts.
Sits between the control sequencer (ctl_* strobes) and the internal data-bus segment drivers.

---
 rtl/bus_switch_pkg.sv | 16 +
 rtl/bus_switch_lane.sv | 121 ++++++++++++
 rtl/bus_switch_seq.sv | 50 +++++
 tb/tb_bus_switch_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_switch_pkg.sv
// Shared definitions for the registered data-bus switch: direction state
// encoding, turnaround counter width and the default downstream bit mask.
package bus_switch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        TURN = 2'd3
    } sw_state_t;

    localparam int CNT_W = 3;

    localparam logic [7:0] DEFAULT_MASK = 8'h38;

endpackage

// File: rtl/bus_switch_lane.sv
// One bidirectional switch: direction FSM with dead-time turnaround,
// downstream mask latch and sticky up/down conflict flag.
module bus_switch_lane
    import bus_switch_pkg::*;
#(
    parameter int            DW       = 8,
    parameter int            DEAD_CYC = 1,
    parameter logic [DW-1:0] MASK     = DW'(DEFAULT_MASK)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          u_i,
    input  logic          d_i,
    input  logic          mask_en_i,
    input  logic          err_clr_i,
    input  logic [DW-1:0] lo_in_i,
    input  logic [DW-1:0] hi_in_i,
    output logic [DW-1:0] hi_out_o,
    output logic          hi_oe_o,
    output logic [DW-1:0] lo_out_o,
    output logic          lo_oe_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(DEAD_CYC - 1);

    sw_state_t        state_q, state_d;
    sw_state_t        target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mask_q, mask_d;
    logic             err_q, err_d;

    logic req_u;
    logic req_d;
    logic conflict;

    // Simultaneous up and down requests are ambiguous and count as no request.
    assign req_u    = u_i & ~d_i;
    assign req_d    = d_i & ~u_i;
    assign conflict = u_i & d_i;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_u) begin
                    state_d = UP;
                end else if (req_d) begin
                    state_d = DOWN;
                end
            end
            UP: begin
                if (req_d) begin
                    state_d  = TURN;
                    target_d = DOWN;
                    cnt_d    = TURN_LOAD;
                end else if (!req_u) begin
                    state_d = IDLE;
                end
            end
            DOWN: begin
                if (req_u) begin
                    state_d  = TURN;
                    target_d = UP;
                    cnt_d    = TURN_LOAD;
                end else if (!req_d) begin
                    state_d = IDLE;
                end
            end
            TURN: begin
                // A fresh request retargets the turnaround but never restarts the dead time.
                if (req_u) begin
                    target_d = UP;
                end else if (req_d) begin
                    target_d = DOWN;
                end
                if (cnt_q == '0) begin
                    if ((target_d == UP && req_u) || (target_d == DOWN && req_d)) begin
                        state_d = target_d;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Mask choice is frozen on entry so it cannot change during a downstream transfer.
        mask_d = ((state_d == DOWN) && (state_q != DOWN)) ? mask_en_i : mask_q;
        err_d  = conflict | (err_q & ~err_clr_i);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= IDLE;
            target_q <= IDLE;
            cnt_q    <= '0;
            mask_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
        end
    end

    assign hi_oe_o  = (state_q == UP);
    assign lo_oe_o  = (state_q == DOWN);
    assign busy_o   = (state_q != IDLE);
    assign err_o    = err_q;
    assign hi_out_o = lo_in_i;
    assign lo_out_o = mask_q ? (hi_in_i & ~MASK) : hi_in_i;

endmodule

// File: rtl/bus_switch_seq.sv
// Registered data-bus switch array: NUM_SW independent lanes joining lower
// and upper bus segments, fed from the control sequencer strobes.
module bus_switch_seq
    import bus_switch_pkg::*;
#(
    parameter int            NUM_SW   = 2,
    parameter int            DW       = 8,
    parameter int            DEAD_CYC = 1,
    parameter logic [DW-1:0] MASK     = DW'(DEFAULT_MASK)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [NUM_SW-1:0]    ctl_sw_u,
    input  logic [NUM_SW-1:0]    ctl_sw_d,
    input  logic [NUM_SW-1:0]    ctl_mask_en,
    input  logic                 err_clr,
    input  logic [NUM_SW*DW-1:0] lo_in,
    input  logic [NUM_SW*DW-1:0] hi_in,
    output logic [NUM_SW*DW-1:0] hi_out,
    output logic [NUM_SW-1:0]    hi_oe,
    output logic [NUM_SW*DW-1:0] lo_out,
    output logic [NUM_SW-1:0]    lo_oe,
    output logic [NUM_SW-1:0]    sw_busy,
    output logic [NUM_SW-1:0]    sw_err
);

    for (genvar i = 0; i < NUM_SW; i++) begin : g_lane
        bus_switch_lane #(
            .DW       (DW),
            .DEAD_CYC (DEAD_CYC),
            .MASK     (MASK)
        ) u_lane (
            .clk       (clk),
            .nreset    (nreset),
            .u_i       (ctl_sw_u[i]),
            .d_i       (ctl_sw_d[i]),
            .mask_en_i (ctl_mask_en[i]),
            .err_clr_i (err_clr),
            .lo_in_i   (lo_in[i*DW +: DW]),
            .hi_in_i   (hi_in[i*DW +: DW]),
            .hi_out_o  (hi_out[i*DW +: DW]),
            .hi_oe_o   (hi_oe[i]),
            .lo_out_o  (lo_out[i*DW +: DW]),
            .lo_oe_o   (lo_oe[i]),
            .busy_o    (sw_busy[i]),
            .err_o     (sw_err[i])
        );
    end

endmodule

// File: tb/tb_bus_switch_seq.sv
// Scoreboard bench for bus_switch_seq with two 8-bit lanes and a three-cycle
// turnaround; stimulus rows are {nreset, err_clr, u[1:0], d[1:0], mask_en[1:0]}.
module tb_bus_switch_seq;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        err_clr = 1'b0;
    logic [1:0]  ctl_sw_u = '0;
    logic [1:0]  ctl_sw_d = '0;
    logic [1:0]  ctl_mask_en = '0;
    logic [15:0] lo_in = '0;
    logic [15:0] hi_in = '0;
    logic [15:0] hi_out;
    logic [15:0] lo_out;
    logic [1:0]  hi_oe;
    logic [1:0]  lo_oe;
    logic [1:0]  sw_busy;
    logic [1:0]  sw_err;
    logic [7:0]  obs;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] ctl;
        logic       chk;
        logic [7:0] dat;
    } exp_t;

    exp_t sb[$];

    bus_switch_seq #(
        .NUM_SW   (2),
        .DW       (8),
        .DEAD_CYC (3),
        .MASK     (8'h38)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .ctl_sw_u    (ctl_sw_u),
        .ctl_sw_d    (ctl_sw_d),
        .ctl_mask_en (ctl_mask_en),
        .err_clr     (err_clr),
        .lo_in       (lo_in),
        .hi_in       (hi_in),
        .hi_out      (hi_out),
        .hi_oe       (hi_oe),
        .lo_out      (lo_out),
        .lo_oe       (lo_oe),
        .sw_busy     (sw_busy),
        .sw_err      (sw_err)
    );

    always #5 clk = ~clk;

    assign obs = {hi_oe, lo_oe, sw_busy, sw_err};

    task automatic apply(input logic [7:0] s);
        {nreset, err_clr, ctl_sw_u, ctl_sw_d, ctl_mask_en} = s;
    endtask

    task automatic test_reset();
        logic [7:0] st [4] = '{8'h3C, 8'h3C, 8'h80, 8'h80};
        logic [7:0] ex [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            sb.push_back('{ctl: ex[i], chk: 1'b0, dat: 8'h00});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.ctl) begin
                errors++;
                $display("FAIL reset[%0d] oe/busy/err: got %h want %h", i, obs, e.ctl);
            end
        end
    endtask

    task automatic test_upstream();
        logic [7:0] st [3] = '{8'h90, 8'h90, 8'h80};
        logic [7:0] ex [3] = '{8'h44, 8'h44, 8'h00};
        logic [7:0] dv [3] = '{8'hA5, 8'h5A, 8'h00};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            lo_in = {8'h3C, dv[i]};
            apply(st[i]);
            sb.push_back('{ctl: ex[i], chk: (i < 2), dat: dv[i]});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.ctl) begin
                errors++;
                $display("FAIL upstream[%0d] oe/busy/err: got %h want %h", i, obs, e.ctl);
            end
            if (e.chk) begin
                checks++;
                if (hi_out[7:0] !== e.dat) begin
                    errors++;
                    $display("FAIL upstream[%0d] hi_out: got %h want %h", i, hi_out[7:0], e.dat);
                end
            end
        end
    endtask

    task automatic test_masked_down();
        logic [7:0] st [7] = '{8'h8A, 8'h88, 8'h8A, 8'h80, 8'h88, 8'h8A, 8'h80};
        logic [7:0] ex [7] = '{8'h28, 8'h28, 8'h28, 8'h00, 8'h28, 8'h28, 8'h00};
        logic [7:0] dv [7] = '{8'hC7, 8'hC7, 8'hC7, 8'h00, 8'hFF, 8'hFF, 8'h00};
        logic       ck [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_t e;
        hi_in = 16'hFF00;
        for (int i = 0; i < 7; i++) begin
            apply(st[i]);
            sb.push_back('{ctl: ex[i], chk: ck[i], dat: dv[i]});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.ctl) begin
                errors++;
                $display("FAIL masked_down[%0d] oe/busy/err: got %h want %h", i, obs, e.ctl);
            end
            if (e.chk) begin
                checks++;
                if (lo_out[15:8] !== e.dat) begin
                    errors++;
                    $display("FAIL masked_down[%0d] lo_out: got %h want %h", i, lo_out[15:8], e.dat);
                end
            end
        end
    endtask

    task automatic test_reversal();
        // Plain reversal, then a reversal retargeted back to UP during the dead time.
        logic [7:0] st [12] = '{8'h90, 8'h84, 8'h84, 8'h84, 8'h84, 8'h80,
                                8'h90, 8'h84, 8'h90, 8'h90, 8'h90, 8'h80};
        logic [7:0] ex [12] = '{8'h44, 8'h04, 8'h04, 8'h04, 8'h14, 8'h00,
                                8'h44, 8'h04, 8'h04, 8'h04, 8'h44, 8'h00};
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            apply(st[i]);
            sb.push_back('{ctl: ex[i], chk: 1'b0, dat: 8'h00});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.ctl) begin
                errors++;
                $display("FAIL reversal[%0d] oe/busy/err: got %h want %h", i, obs, e.ctl);
            end
            checks++;
            if ((hi_oe & lo_oe) !== 2'b00) begin
                errors++;
                $display("FAIL reversal[%0d] both_oe: got %b want 00", i, hi_oe & lo_oe);
            end
        end
    endtask

    task automatic test_conflict();
        logic [7:0] st [8] = '{8'h94, 8'h80, 8'hD4, 8'hC0, 8'h80, 8'h90, 8'h94, 8'hC0};
        logic [7:0] ex [8] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h44, 8'h01, 8'h00};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            apply(st[i]);
            sb.push_back('{ctl: ex[i], chk: 1'b0, dat: 8'h00});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.ctl) begin
                errors++;
                $display("FAIL conflict[%0d] oe/busy/err: got %h want %h", i, obs, e.ctl);
            end
        end
    endtask

    task automatic test_reset_mid_turn();
        logic [7:0] st [7] = '{8'h90, 8'h84, 8'h04, 8'h90, 8'h94, 8'h14, 8'h80};
        logic [7:0] ex [7] = '{8'h44, 8'h04, 8'h00, 8'h44, 8'h01, 8'h00, 8'h00};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            apply(st[i]);
            sb.push_back('{ctl: ex[i], chk: 1'b0, dat: 8'h00});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.ctl) begin
                errors++;
                $display("FAIL reset_mid_turn[%0d] oe/busy/err: got %h want %h", i, obs, e.ctl);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] st [6] = '{8'h98, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'h80};
        logic [7:0] ex [6] = '{8'h6C, 8'h0C, 8'h0C, 8'h0C, 8'h9C, 8'h00};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            apply(st[i]);
            sb.push_back('{ctl: ex[i], chk: 1'b0, dat: 8'h00});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e.ctl) begin
                errors++;
                $display("FAIL back_to_back[%0d] oe/busy/err: got %h want %h", i, obs, e.ctl);
            end
            checks++;
            if ((hi_oe & lo_oe) !== 2'b00) begin
                errors++;
                $display("FAIL back_to_back[%0d] both_oe: got %b want 00", i, hi_oe & lo_oe);
            end
        end
    endtask

    initial begin
        test_reset();
        test_upstream();
        test_masked_down();
        test_reversal();
        test_conflict();
        test_reset_mid_turn();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
